// File: rtl/rtp_rx_depacketizer.sv
// rtp_rx_depacketizer
//   Receive-side RTP (RFC3550) + RFC4175 header parser on a 32-bit AXIS stream.
//   Validates the five header words, tracks 32-bit extended sequence continuity,
//   strips the header and forwards the payload with zero latency.
//   Optional build macro RTP_RX_SSRC_FILTER_EN: drop packets whose SSRC differs
//   from ssrc_filter (checked on the SSRC word).
module rtp_rx_depacketizer #(
    parameter int PAYLOAD_TYPE = 96,
    parameter int CNT_WIDTH    = 16
) (
    input  logic                 aclk,
    input  logic                 aresetn,
    input  logic                 enable,
    input  logic [31:0]          ssrc_filter,
    input  logic                 s_axis_tvalid,
    output logic                 s_axis_tready,
    input  logic [31:0]          s_axis_tdata,
    input  logic                 s_axis_tlast,
    output logic                 m_axis_tvalid,
    input  logic                 m_axis_tready,
    output logic [31:0]          m_axis_tdata,
    output logic                 m_axis_tlast,
    output logic                 m_axis_tuser,
    output logic [31:0]          seq_number,
    output logic [31:0]          rtp_timestamp,
    output logic [31:0]          rtp_ssrc,
    output logic [31:0]          line_info,
    output logic [CNT_WIDTH-1:0] pkt_cnt,
    output logic [CNT_WIDTH-1:0] drop_cnt,
    output logic [CNT_WIDTH-1:0] seq_err_cnt,
    output logic                 busy
);

    localparam logic [6:0] LP_PT = PAYLOAD_TYPE[6:0];

    typedef enum logic [2:0] {
        S_IDLE, S_H0, S_H1, S_H2, S_H3, S_H4, S_PAYLOAD, S_DROP
    } state_t;

    state_t r_state, w_next;

    // Shadow header fields: only become visible once the whole header is good
    logic [15:0]          r_sh_seq;
    logic [31:0]          r_sh_ts;
    logic [31:0]          r_sh_ssrc;
    logic [15:0]          r_sh_ext;

    logic [31:0]          r_seq_number, r_timestamp, r_ssrc, r_line_info;
    logic [CNT_WIDTH-1:0] r_pkt_cnt, r_drop_cnt, r_seq_err_cnt;
    logic                 r_seq_valid;
    logic                 r_enable_q;
    logic                 r_first;   // next payload beat is the first of the packet
    logic                 r_sof;     // accepted packet starts a frame (F=0, line 0, offset 0)

    logic                 w_s_hs;
    logic                 w_in_hdr;
    logic                 w_hdr_err;
    logic                 w_ssrc_err;
    logic                 w_drop_evt;
    logic                 w_accept;
    logic [31:0]          w_cur_seq;

`ifdef RTP_RX_SSRC_FILTER_EN
    assign w_ssrc_err = (s_axis_tdata != ssrc_filter);
`else
    // Filter disabled: SSRC is captured only, the compare value is ignored
    logic w_unused_ssrc_filter;
    assign w_unused_ssrc_filter = ^ssrc_filter;
    assign w_ssrc_err           = 1'b0;
`endif

    assign w_s_hs     = s_axis_tvalid & s_axis_tready;
    assign w_in_hdr   = (r_state == S_H0) | (r_state == S_H1) | (r_state == S_H2) |
                        (r_state == S_H3) | (r_state == S_H4);
    // A short packet (tlast before W4) and a failed field check both count once
    assign w_drop_evt = w_s_hs & w_in_hdr &
                        (w_hdr_err | (s_axis_tlast & (r_state != S_H4)));
    assign w_accept   = w_s_hs & (r_state == S_H4) & ~w_hdr_err;
    assign w_cur_seq  = {r_sh_ext, r_sh_seq};

    // Per-word header field checks for the word currently on the input
    always_comb begin
        w_hdr_err = 1'b0;
        case (r_state)
            S_H0:    w_hdr_err = (s_axis_tdata[31:30] != 2'd2) | s_axis_tdata[29] |
                                 s_axis_tdata[28] | (s_axis_tdata[27:24] != 4'd0) |
                                 (s_axis_tdata[22:16] != LP_PT);
            S_H2:    w_hdr_err = w_ssrc_err;
            S_H4:    w_hdr_err = s_axis_tdata[15];   // continuation bit: multi-line not supported
            default: w_hdr_err = 1'b0;
        endcase
    end

    // State register
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) r_state <= S_IDLE;
        else          r_state <= w_next;
    end

    // Next-state logic
    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE: if (enable && s_axis_tvalid) w_next = S_H0;
            S_H0, S_H1, S_H2, S_H3, S_H4: begin
                if (w_s_hs) begin
                    if (w_hdr_err || s_axis_tlast) w_next = (s_axis_tlast) ? S_IDLE : S_DROP;
                    else begin
                        case (r_state)
                            S_H0:    w_next = S_H1;
                            S_H1:    w_next = S_H2;
                            S_H2:    w_next = S_H3;
                            S_H3:    w_next = S_H4;
                            default: w_next = S_PAYLOAD;
                        endcase
                    end
                end
            end
            S_PAYLOAD, S_DROP: if (w_s_hs && s_axis_tlast) w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    // Outputs: header/drop states sink, payload is a straight pass-through
    always_comb begin
        s_axis_tready = 1'b1;
        m_axis_tvalid = 1'b0;
        m_axis_tlast  = 1'b0;
        m_axis_tuser  = 1'b0;
        m_axis_tdata  = s_axis_tdata;
        case (r_state)
            S_IDLE:    s_axis_tready = ~enable;   // disabled: swallow input beats
            S_PAYLOAD: begin
                s_axis_tready = m_axis_tready;
                m_axis_tvalid = s_axis_tvalid;
                m_axis_tlast  = s_axis_tlast;
                m_axis_tuser  = r_first & r_sof;
            end
            default:   s_axis_tready = 1'b1;
        endcase
    end

    // Header capture, publication, sequence tracking and counters
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            r_sh_seq      <= '0;
            r_sh_ts       <= '0;
            r_sh_ssrc     <= '0;
            r_sh_ext      <= '0;
            r_seq_number  <= '0;
            r_timestamp   <= '0;
            r_ssrc        <= '0;
            r_line_info   <= '0;
            r_pkt_cnt     <= '0;
            r_drop_cnt    <= '0;
            r_seq_err_cnt <= '0;
            r_seq_valid   <= 1'b0;
            r_enable_q    <= 1'b0;
            r_first       <= 1'b0;
            r_sof         <= 1'b0;
        end else begin
            r_enable_q <= enable;
            // Re-enabling starts a fresh sequence history
            if (enable && !r_enable_q) r_seq_valid <= 1'b0;

            if (w_s_hs) begin
                case (r_state)
                    S_H0:    r_sh_seq  <= s_axis_tdata[15:0];
                    S_H1:    r_sh_ts   <= s_axis_tdata;
                    S_H2:    r_sh_ssrc <= s_axis_tdata;
                    S_H3:    r_sh_ext  <= s_axis_tdata[31:16];
                    default: ;
                endcase
            end

            if (w_drop_evt && (r_drop_cnt != {CNT_WIDTH{1'b1}}))
                r_drop_cnt <= r_drop_cnt + 1'b1;

            if (w_accept) begin
                r_timestamp  <= r_sh_ts;
                r_ssrc       <= r_sh_ssrc;
                r_line_info  <= s_axis_tdata;
                r_seq_number <= w_cur_seq;
                r_seq_valid  <= 1'b1;
                r_sof        <= ~s_axis_tdata[31] & (s_axis_tdata[30:16] == 15'd0) &
                                (s_axis_tdata[14:0] == 15'd0);
                r_first      <= 1'b1;
                if (r_pkt_cnt != {CNT_WIDTH{1'b1}})
                    r_pkt_cnt <= r_pkt_cnt + 1'b1;
                // 32-bit compare wraps naturally: FFFF_FFFF -> 0 is in order
                if (r_seq_valid && (w_cur_seq != r_seq_number + 32'd1) &&
                    (r_seq_err_cnt != {CNT_WIDTH{1'b1}}))
                    r_seq_err_cnt <= r_seq_err_cnt + 1'b1;
            end else if ((r_state == S_PAYLOAD) && w_s_hs) begin
                r_first <= 1'b0;
            end
        end
    end

    assign seq_number    = r_seq_number;
    assign rtp_timestamp = r_timestamp;
    assign rtp_ssrc      = r_ssrc;
    assign line_info     = r_line_info;
    assign pkt_cnt       = r_pkt_cnt;
    assign drop_cnt      = r_drop_cnt;
    assign seq_err_cnt   = r_seq_err_cnt;
    assign busy          = (r_state != S_IDLE);

endmodule

// File: tb/tb_rtp_rx_depacketizer.sv
// Directed bench for rtp_rx_depacketizer: one task per scenario, inline checks.
module tb_rtp_rx_depacketizer;

    logic        aclk, aresetn, enable;
    logic [31:0] ssrc_filter;
    logic        s_axis_tvalid, s_axis_tready, s_axis_tlast;
    logic [31:0] s_axis_tdata;
    logic        m_axis_tvalid, m_axis_tready, m_axis_tlast, m_axis_tuser;
    logic [31:0] m_axis_tdata;
    logic [31:0] seq_number, rtp_timestamp, rtp_ssrc, line_info;
    logic [15:0] pkt_cnt, drop_cnt, seq_err_cnt;
    logic        busy;

    int checks = 0;
    int failures = 0;

    // Output beat capture
    logic [31:0] beat_data [32];
    logic        beat_user [32];
    logic        beat_last [32];
    int          nbeats = 0;
    bit          stall_chk = 0;
    int          stall_err = 0;

    rtp_rx_depacketizer #(.PAYLOAD_TYPE(96), .CNT_WIDTH(16)) dut (
        .aclk(aclk), .aresetn(aresetn), .enable(enable), .ssrc_filter(ssrc_filter),
        .s_axis_tvalid(s_axis_tvalid), .s_axis_tready(s_axis_tready),
        .s_axis_tdata(s_axis_tdata), .s_axis_tlast(s_axis_tlast),
        .m_axis_tvalid(m_axis_tvalid), .m_axis_tready(m_axis_tready),
        .m_axis_tdata(m_axis_tdata), .m_axis_tlast(m_axis_tlast), .m_axis_tuser(m_axis_tuser),
        .seq_number(seq_number), .rtp_timestamp(rtp_timestamp), .rtp_ssrc(rtp_ssrc),
        .line_info(line_info), .pkt_cnt(pkt_cnt), .drop_cnt(drop_cnt),
        .seq_err_cnt(seq_err_cnt), .busy(busy)
    );

    initial begin
        aclk = 1'b0;
        forever #5 aclk = ~aclk;
    end

    // Record beats that will transfer on the coming rising edge
    always @(negedge aclk) begin
        if (m_axis_tvalid && m_axis_tready && nbeats < 32) begin
            beat_data[nbeats] = m_axis_tdata;
            beat_user[nbeats] = m_axis_tuser;
            beat_last[nbeats] = m_axis_tlast;
            nbeats++;
        end
        if (stall_chk && m_axis_tvalid && (s_axis_tready !== m_axis_tready)) stall_err++;
    end

    task automatic tick(input int n);
        repeat (n) @(posedge aclk);
        #1;
    endtask

    task automatic send_word(input logic [31:0] d, input logic last, output int waits);
        int n = 0;
        s_axis_tvalid = 1'b1;
        s_axis_tdata  = d;
        s_axis_tlast  = last;
        while (1) begin
            @(negedge aclk);
            if (s_axis_tready) break;
            n++;
            if (n > 200) break;
        end
        if (n > 200) begin
            checks++; failures++;
            $display("FAIL send_timeout got=no_tready exp=tready within 200 cycles");
        end
        @(posedge aclk);
        #1;
        s_axis_tvalid = 1'b0;
        s_axis_tlast  = 1'b0;
        waits = n;
    endtask

    // Five header words (timestamp fixed at 1000) followed by npay payload beats
    task automatic send_pkt(input logic [31:0] w0, input logic [31:0] ssrc, input logic [31:0] w3,
                            input logic [31:0] w4, input int npay, input logic [31:0] base,
                            output int waits);
        int w;
        int tot = 0;
        send_word(w0, 1'b0, w);
        send_word(32'd1000, 1'b0, w); tot += w;
        send_word(ssrc, 1'b0, w);     tot += w;
        send_word(w3, 1'b0, w);       tot += w;
        send_word(w4, (npay == 0), w); tot += w;
        for (int i = 0; i < npay; i++) begin
            send_word(base + i, (i == npay - 1), w);
            tot += w;
        end
        waits = tot;
    endtask

    task automatic test_reset();
        aresetn = 1'b0;
        tick(3);
        checks++; if (seq_number !== 32'd0) begin failures++; $display("FAIL rst_seq got=%h exp=0", seq_number); end
        checks++; if (rtp_timestamp !== 32'd0) begin failures++; $display("FAIL rst_ts got=%h exp=0", rtp_timestamp); end
        checks++; if (rtp_ssrc !== 32'd0) begin failures++; $display("FAIL rst_ssrc got=%h exp=0", rtp_ssrc); end
        checks++; if (line_info !== 32'd0) begin failures++; $display("FAIL rst_line got=%h exp=0", line_info); end
        checks++; if ({pkt_cnt, drop_cnt, seq_err_cnt} !== 48'd0) begin failures++; $display("FAIL rst_cnts got=%h exp=0", {pkt_cnt, drop_cnt, seq_err_cnt}); end
        checks++; if (busy !== 1'b0 || m_axis_tvalid !== 1'b0) begin failures++; $display("FAIL rst_busy_tvalid got=%b%b exp=00", busy, m_axis_tvalid); end
        aresetn = 1'b1;
        tick(2);
    endtask

    task automatic test_good_packet();
        int w;
        nbeats = 0;
        send_pkt(32'h8060_0005, 32'hCAFE_0001, 32'h0000_0008, 32'h0, 2, 32'hA1, w);
        tick(2);
        checks++; if (nbeats !== 2) begin failures++; $display("FAIL good_nbeats got=%0d exp=2", nbeats); end
        checks++; if ({beat_data[0], beat_user[0], beat_last[0]} !== {32'hA1, 1'b1, 1'b0}) begin failures++; $display("FAIL good_beat0 got=%h/%b/%b exp=a1/1/0", beat_data[0], beat_user[0], beat_last[0]); end
        checks++; if ({beat_data[1], beat_user[1], beat_last[1]} !== {32'hA2, 1'b0, 1'b1}) begin failures++; $display("FAIL good_beat1 got=%h/%b/%b exp=a2/0/1", beat_data[1], beat_user[1], beat_last[1]); end
        checks++; if (pkt_cnt !== 16'd1) begin failures++; $display("FAIL good_pkt_cnt got=%0d exp=1", pkt_cnt); end
        checks++; if (seq_number !== 32'd5) begin failures++; $display("FAIL good_seq got=%h exp=5", seq_number); end
        checks++; if (rtp_timestamp !== 32'd1000 || rtp_ssrc !== 32'hCAFE_0001) begin failures++; $display("FAIL good_ts_ssrc got=%0d/%h exp=1000/cafe0001", rtp_timestamp, rtp_ssrc); end
        checks++; if (seq_err_cnt !== 16'd0 || busy !== 1'b0) begin failures++; $display("FAIL good_err_busy got=%0d/%b exp=0/0", seq_err_cnt, busy); end
    endtask

    task automatic test_seq_gap();
        int w;
        nbeats = 0;
        send_pkt(32'h8060_0007, 32'hCAFE_0001, 32'h0000_0008, 32'h0, 1, 32'hB1, w);
        tick(1);
        checks++; if (seq_err_cnt !== 16'd1 || pkt_cnt !== 16'd2) begin failures++; $display("FAIL gap_err got=%0d/%0d exp=1/2", seq_err_cnt, pkt_cnt); end
        send_pkt(32'h8060_0008, 32'hCAFE_0001, 32'h0000_0008, 32'h0, 1, 32'hB2, w);
        tick(1);
        checks++; if (seq_err_cnt !== 16'd1 || pkt_cnt !== 16'd3) begin failures++; $display("FAIL gap_inorder got=%0d/%0d exp=1/3", seq_err_cnt, pkt_cnt); end
        checks++; if (nbeats !== 2 || beat_data[0] !== 32'hB1 || beat_data[1] !== 32'hB2) begin failures++; $display("FAIL gap_fwd got=%0d/%h/%h exp=2/b1/b2", nbeats, beat_data[0], beat_data[1]); end
        checks++; if (seq_number !== 32'd8) begin failures++; $display("FAIL gap_seq got=%h exp=8", seq_number); end
    endtask

    task automatic test_wrap();
        int w;
        send_pkt(32'h8060_FFFF, 32'hCAFE_0001, 32'hFFFF_0008, 32'h0, 1, 32'hC0, w);
        tick(1);
        checks++; if (seq_err_cnt !== 16'd2 || seq_number !== 32'hFFFF_FFFF) begin failures++; $display("FAIL wrap_pre got=%0d/%h exp=2/ffffffff", seq_err_cnt, seq_number); end
        send_pkt(32'h8060_0000, 32'hCAFE_0001, 32'h0000_0008, 32'h0, 1, 32'hC1, w);
        tick(1);
        checks++; if (seq_err_cnt !== 16'd2 || seq_number !== 32'd0 || pkt_cnt !== 16'd5) begin failures++; $display("FAIL wrap_post got=%0d/%h/%0d exp=2/0/5", seq_err_cnt, seq_number, pkt_cnt); end
    endtask

    task automatic test_drop();
        int w;
        nbeats = 0;
        send_pkt(32'h8061_0009, 32'hCAFE_0001, 32'h0000_0008, 32'h0, 2, 32'hD0, w);
        tick(1);
        checks++; if (nbeats !== 0 || drop_cnt !== 16'd1 || pkt_cnt !== 16'd5) begin failures++; $display("FAIL pt_drop got=%0d/%0d/%0d exp=0/1/5", nbeats, drop_cnt, pkt_cnt); end
        checks++; if (w !== 0 || busy !== 1'b0) begin failures++; $display("FAIL pt_tready got=%0d/%b exp=0/0", w, busy); end
        // Short packet: tlast on the SSRC word
        send_word(32'h8060_0001, 1'b0, w);
        send_word(32'd1000, 1'b0, w);
        send_word(32'hCAFE_0001, 1'b1, w);
        tick(1);
        checks++; if (drop_cnt !== 16'd2 || busy !== 1'b0 || nbeats !== 0) begin failures++; $display("FAIL short_drop got=%0d/%b/%0d exp=2/0/0", drop_cnt, busy, nbeats); end
        checks++; if (pkt_cnt !== 16'd5 || seq_number !== 32'd0) begin failures++; $display("FAIL short_state got=%0d/%h exp=5/0", pkt_cnt, seq_number); end
    endtask

    task automatic test_header_only();
        int w;
        nbeats = 0;
        send_pkt(32'h8060_0001, 32'hCAFE_0001, 32'h0000_0008, 32'h0, 0, 32'h0, w);
        tick(1);
        checks++; if (pkt_cnt !== 16'd6 || nbeats !== 0 || seq_number !== 32'd1 || busy !== 1'b0) begin failures++; $display("FAIL hdr_only got=%0d/%0d/%h/%b exp=6/0/1/0", pkt_cnt, nbeats, seq_number, busy); end
        // Continuation bit set in line header
        send_pkt(32'h8060_0002, 32'hCAFE_0001, 32'h0000_0008, 32'h0000_8000, 1, 32'hE0, w);
        tick(1);
        checks++; if (drop_cnt !== 16'd3 || pkt_cnt !== 16'd6 || nbeats !== 0 || seq_number !== 32'd1) begin failures++; $display("FAIL cbit_drop got=%0d/%0d/%0d/%h exp=3/6/0/1", drop_cnt, pkt_cnt, nbeats, seq_number); end
    endtask

    task automatic test_line_info();
        int w;
        nbeats = 0;
        send_pkt(32'h8060_0002, 32'hCAFE_0001, 32'h0000_0008, 32'h0001_0000, 1, 32'hF1, w);
        tick(1);
        checks++; if (nbeats !== 1 || beat_user[0] !== 1'b0 || beat_last[0] !== 1'b1) begin failures++; $display("FAIL line_tuser got=%0d/%b/%b exp=1/0/1", nbeats, beat_user[0], beat_last[0]); end
        checks++; if (line_info !== 32'h0001_0000 || pkt_cnt !== 16'd7 || seq_err_cnt !== 16'd2) begin failures++; $display("FAIL line_info got=%h/%0d/%0d exp=00010000/7/2", line_info, pkt_cnt, seq_err_cnt); end
    endtask

    task automatic test_backpressure();
        int w;
        bit done = 0;
        nbeats = 0;
        stall_err = 0;
        stall_chk = 1;
        fork
            begin
                send_pkt(32'h8060_0003, 32'hCAFE_0001, 32'h0000_0008, 32'h0, 16, 32'h100, w);
                done = 1;
            end
            begin
                while (!done) begin
                    @(posedge aclk);
                    #1;
                    m_axis_tready = ~m_axis_tready;
                end
            end
        join
        stall_chk = 0;
        m_axis_tready = 1'b1;
        tick(1);
        checks++; if (nbeats !== 16) begin failures++; $display("FAIL bp_nbeats got=%0d exp=16", nbeats); end
        for (int i = 0; i < 16; i++) begin
            checks++; if (beat_data[i] !== 32'h100 + i || beat_last[i] !== (i == 15) || beat_user[i] !== (i == 0)) begin failures++; $display("FAIL bp_beat%0d got=%h/%b/%b exp=%h", i, beat_data[i], beat_user[i], beat_last[i], 32'h100 + i); end
        end
        checks++; if (stall_err !== 0 || pkt_cnt !== 16'd8) begin failures++; $display("FAIL bp_stall got=%0d/%0d exp=0/8", stall_err, pkt_cnt); end
    endtask

    task automatic test_enable();
        int w;
        nbeats = 0;
        enable = 1'b0;
        tick(1);
        send_pkt(32'h8060_0010, 32'hCAFE_0001, 32'h0000_0008, 32'h0, 1, 32'h77, w);
        tick(1);
        checks++; if (nbeats !== 0 || pkt_cnt !== 16'd8 || drop_cnt !== 16'd3 || seq_number !== 32'd3 || busy !== 1'b0) begin failures++; $display("FAIL en_sink got=%0d/%0d/%0d/%h/%b exp=0/8/3/3/0", nbeats, pkt_cnt, drop_cnt, seq_number, busy); end
        enable = 1'b1;
        tick(1);
        send_pkt(32'h8060_0020, 32'hCAFE_0001, 32'h0000_0008, 32'h0, 1, 32'h78, w);
        tick(1);
        checks++; if (pkt_cnt !== 16'd9 || seq_err_cnt !== 16'd2 || seq_number !== 32'h20 || nbeats !== 1) begin failures++; $display("FAIL en_resync got=%0d/%0d/%h/%0d exp=9/2/20/1", pkt_cnt, seq_err_cnt, seq_number, nbeats); end
    endtask

    task automatic test_ssrc();
        int w;
        nbeats = 0;
        ssrc_filter = 32'h0000_1234;
        send_pkt(32'h8060_0021, 32'hCAFE_0001, 32'h0000_0008, 32'h0, 1, 32'h99, w);
        tick(1);
`ifdef RTP_RX_SSRC_FILTER_EN
        checks++; if (drop_cnt !== 16'd4 || pkt_cnt !== 16'd9 || nbeats !== 0 || seq_number !== 32'h20) begin failures++; $display("FAIL ssrc_filter got=%0d/%0d/%0d/%h exp=4/9/0/20", drop_cnt, pkt_cnt, nbeats, seq_number); end
`else
        checks++; if (drop_cnt !== 16'd3 || pkt_cnt !== 16'd10 || nbeats !== 1 || seq_number !== 32'h21) begin failures++; $display("FAIL ssrc_ignored got=%0d/%0d/%0d/%h exp=3/10/1/21", drop_cnt, pkt_cnt, nbeats, seq_number); end
`endif
        ssrc_filter = 32'hCAFE_0001;
    endtask

    initial begin
        aresetn       = 1'b0;
        enable        = 1'b1;
        ssrc_filter   = 32'hCAFE_0001;
        s_axis_tvalid = 1'b0;
        s_axis_tdata  = 32'd0;
        s_axis_tlast  = 1'b0;
        m_axis_tready = 1'b1;
        test_reset();
        test_good_packet();
        test_seq_gap();
        test_wrap();
        test_drop();
        test_header_only();
        test_line_info();
        test_backpressure();
        test_enable();
        test_ssrc();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
